// File: rtl/adc_fe_pkg.sv
// Shared definitions for the ADC LVDS front end: alignment FSM states and
// default geometry of the deserializer.
package adc_fe_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } align_state_t;

    localparam int unsigned    DEF_LANES         = 8;
    localparam int unsigned    DEF_WORD_BITS     = 16;
    localparam logic [15:0]    DEF_FRAME_PATTERN = 16'hFF00;
    localparam int unsigned    DEF_LOCK_COUNT    = 4;

endpackage

// File: rtl/ddr_deser_align_if.sv
// Deserialized output bus: aligned words, strobe and alignment status.
interface ddr_deser_align_if
    import adc_fe_pkg::*;
#(
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned WORD_BITS = DEF_WORD_BITS
);

    logic [LANES*WORD_BITS-1:0]     data_out;
    logic                           data_valid;
    logic                           locked;
    logic [$clog2(WORD_BITS)-1:0]   slip_count;
    logic                           align_err;

    modport master (
        output data_out,
        output data_valid,
        output locked,
        output slip_count,
        output align_err
    );

    modport slave (
        input data_out,
        input data_valid,
        input locked,
        input slip_count,
        input align_err
    );

endinterface

// File: rtl/ddr_lane_shifter.sv
// One DDR lane: both-edge capture, 2*WORD_BITS history and the slip-selected
// word window (newest bit at LSB, rising-edge bit older than falling-edge bit).
module ddr_lane_shifter
    import adc_fe_pkg::*;
#(
    parameter int unsigned WORD_BITS = DEF_WORD_BITS
) (
    input  logic                          dco_clk,
    input  logic                          rst_n,
    input  logic                          din,
    input  logic [$clog2(WORD_BITS)-1:0]  slip,
    output logic [WORD_BITS-1:0]          window
);

    logic                    rise_q;
    logic                    fall_q;
    logic [2*WORD_BITS-1:0]  sr;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= din;
        end
    end

    always_ff @(negedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= din;
        end
    end

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[2*WORD_BITS-3:0], rise_q, fall_q};
        end
    end

    // Shift-then-truncate keeps the select in range for any slip encoding.
    assign window = WORD_BITS'(sr >> slip);

endmodule

// File: rtl/ddr_deser_align.sv
// Multi-lane DDR deserializer with frame-lane (FCO) driven bit-slip alignment.
// Data words are emitted every WORD_BITS/2 cycles independent of lock state.
module ddr_deser_align
    import adc_fe_pkg::*;
#(
    parameter int unsigned            LANES         = DEF_LANES,
    parameter int unsigned            WORD_BITS     = DEF_WORD_BITS,
    parameter logic [WORD_BITS-1:0]   FRAME_PATTERN = WORD_BITS'(DEF_FRAME_PATTERN),
    parameter int unsigned            LOCK_COUNT    = DEF_LOCK_COUNT
) (
    input  logic              dco_clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  lvds_data,
    input  logic              lvds_frame,
    input  logic              align_en,
    ddr_deser_align_if.master deser
);

    localparam int unsigned SW   = $clog2(WORD_BITS);
    localparam int unsigned HALF = WORD_BITS / 2;
    localparam int unsigned CW   = $clog2(HALF) > 0 ? $clog2(HALF) : 1;

    logic [LANES:0]             lane_in;
    logic [WORD_BITS-1:0]       win [LANES+1];
    logic [CW-1:0]              word_cnt;
    logic                       strobe;
    logic                       frame_match;
    logic [SW-1:0]              slip;
    logic [SW-1:0]              slip_next;

    logic [LANES*WORD_BITS-1:0] data_r;
    logic                       valid_r;

    align_state_t               state;
    logic [3:0]                 match_cnt;
    logic                       miss;
    logic [SW-1:0]              sweep_cnt;
    logic                       locked_r;
    logic                       err_r;

    assign lane_in = {lvds_frame, lvds_data};

    // Index LANES is the frame lane; it shares the slip with the data lanes.
    for (genvar i = 0; i <= LANES; i++) begin : g_lane
        ddr_lane_shifter #(
            .WORD_BITS (WORD_BITS)
        ) u_lane (
            .dco_clk (dco_clk),
            .rst_n   (rst_n),
            .din     (lane_in[i]),
            .slip    (slip),
            .window  (win[i])
        );
    end

    assign strobe      = (word_cnt == CW'(HALF - 1));
    assign frame_match = (win[LANES] == FRAME_PATTERN);
    assign slip_next   = (slip == SW'(WORD_BITS - 1)) ? '0 : slip + 1'b1;

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            word_cnt <= strobe ? '0 : word_cnt + 1'b1;
            valid_r  <= strobe;
            if (strobe) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    data_r[i*WORD_BITS +: WORD_BITS] <= win[i];
                end
            end
        end
    end

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            slip      <= '0;
            match_cnt <= '0;
            miss      <= 1'b0;
            sweep_cnt <= '0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (!align_en) begin
                state     <= SEARCH;
                match_cnt <= '0;
                miss      <= 1'b0;
                sweep_cnt <= '0;
                locked_r  <= 1'b0;
            end else if (strobe) begin
                case (state)
                    SEARCH: begin
                        if (frame_match) begin
                            sweep_cnt <= '0;
                            match_cnt <= 4'd1;
                            if (LOCK_COUNT == 1) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state <= CHECK;
                            end
                        end else begin
                            slip <= slip_next;
                            // A full sweep without a match is reported, then retried.
                            if (sweep_cnt == SW'(WORD_BITS - 1)) begin
                                err_r     <= 1'b1;
                                sweep_cnt <= '0;
                            end else begin
                                sweep_cnt <= sweep_cnt + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (frame_match) begin
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) == 4'(LOCK_COUNT)) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            slip      <= slip_next;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (frame_match) begin
                            miss <= 1'b0;
                        end else if (miss) begin
                            state     <= SEARCH;
                            locked_r  <= 1'b0;
                            err_r     <= 1'b1;
                            miss      <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            miss <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign deser.data_out   = data_r;
    assign deser.data_valid = valid_r;
    assign deser.locked     = locked_r;
    assign deser.slip_count = slip;
    assign deser.align_err  = err_r;

endmodule

// File: tb/tb_ddr_deser_align.sv
// Bench for ddr_deser_align: random lane data against a bit-stream reference
// model, plus directed lock, slip, corruption, sweep and enable scenarios.
module tb_ddr_deser_align;

    localparam int unsigned LANES = 2;
    localparam int unsigned W     = 16;
    localparam int unsigned HALF  = W / 2;
    localparam int unsigned LOCK  = 4;
    localparam logic [15:0] FRAME = 16'hFF00;

    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic             dco_clk    = 1'b0;
    logic             rst_n      = 1'b1;
    logic [LANES-1:0] lvds_data  = '0;
    logic             lvds_frame = 1'b0;
    logic             align_en   = 1'b0;

    ddr_deser_align_if #(.LANES(LANES), .WORD_BITS(W)) deser ();

    ddr_deser_align #(
        .LANES         (LANES),
        .WORD_BITS     (W),
        .FRAME_PATTERN (FRAME),
        .LOCK_COUNT    (LOCK)
    ) dut (
        .dco_clk    (dco_clk),
        .rst_n      (rst_n),
        .lvds_data  (lvds_data),
        .lvds_frame (lvds_frame),
        .align_en   (align_en),
        .deser      (deser)
    );

    always #5 dco_clk = ~dco_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus: serial stream position b maps to word (b+off)/W, MSB first.
    int          off        = 0;
    bit          frame_zero = 0;
    bit          fix_l0     = 0;
    logic [15:0] l0_word    = '0;
    bit          corrupt [int];
    logic [15:0] words [int];

    function automatic logic gen_bit(int lane, int b);
        int          pos;
        int          w;
        int          key;
        logic [15:0] word;
        pos = b + off;
        w   = pos / W;
        if (lane == LANES) begin
            if (frame_zero) return 1'b0;
            word = corrupt.exists(w) ? ~FRAME : FRAME;
        end else if (lane == 0 && fix_l0) begin
            word = l0_word;
        end else begin
            key = lane * 1000000 + w;
            if (!words.exists(key)) words[key] = 16'($urandom);
            word = words[key];
        end
        return word[W - 1 - (pos % W)];
    endfunction

    // Reference model: per-lane bit history, alignment rules at word strobes.
    bit                    q [LANES+1][$];
    int                    m_k, m_state, m_slip, m_match, m_miss, m_sweep;
    logic [LANES:0]        prev_r, prev_f;
    logic [LANES*W-1:0]    exp_data;
    logic                  exp_valid, exp_locked, exp_err;
    int                    exp_slip;
    int                    obs_err, obs_valid;

    function automatic logic [15:0] win(int lane, int s);
        logic [15:0] v;
        int          n;
        n = q[lane].size();
        for (int j = 0; j < W; j++) v[j] = q[lane][n - 1 - s - j];
        return v;
    endfunction

    task automatic model_reset();
        for (int l = 0; l <= LANES; l++) begin
            q[l].delete();
            repeat (2 * W) q[l].push_back(1'b0);
        end
        prev_r = '0; prev_f = '0;
        m_k = 0; m_state = M_SEARCH; m_slip = 0; m_match = 0; m_miss = 0; m_sweep = 0;
        exp_data = '0; exp_valid = 0; exp_locked = 0; exp_err = 0; exp_slip = 0;
    endtask

    task automatic model_edge(input logic [LANES:0] cur_r, input logic [LANES:0] cur_f);
        bit match;
        exp_valid = 0;
        exp_err   = 0;
        if (m_k % HALF == HALF - 1) begin
            exp_valid = 1;
            for (int l = 0; l < LANES; l++) exp_data[l*W +: W] = win(l, m_slip);
            if (align_en) begin
                match = (win(LANES, m_slip) == FRAME);
                if (m_state == M_SEARCH) begin
                    if (match) begin
                        m_sweep = 0; m_match = 1;
                        m_state = (LOCK == 1) ? M_LOCKED : M_CHECK;
                    end else begin
                        m_slip = (m_slip + 1) % W;
                        m_sweep++;
                        if (m_sweep == W) begin exp_err = 1; m_sweep = 0; end
                    end
                end else if (m_state == M_CHECK) begin
                    if (match) begin
                        m_match++;
                        if (m_match == LOCK) m_state = M_LOCKED;
                    end else begin
                        m_state = M_SEARCH; m_slip = (m_slip + 1) % W; m_match = 0;
                    end
                end else begin
                    if (match) m_miss = 0;
                    else if (m_miss != 0) begin
                        m_state = M_SEARCH; exp_err = 1; m_miss = 0; m_match = 0;
                    end else m_miss = 1;
                end
            end
        end
        if (!align_en) begin
            m_state = M_SEARCH; m_match = 0; m_miss = 0; m_sweep = 0;
        end
        for (int l = 0; l <= LANES; l++) begin
            q[l].push_back(prev_r[l]);
            q[l].push_back(prev_f[l]);
        end
        prev_r = cur_r; prev_f = cur_f;
        m_k++;
        exp_locked = (m_state == M_LOCKED);
        exp_slip   = m_slip;
    endtask

    task automatic step();
        logic [LANES:0] r, f;
        for (int l = 0; l <= LANES; l++) begin
            r[l] = gen_bit(l, 2 * m_k);
            f[l] = gen_bit(l, 2 * m_k + 1);
        end
        @(negedge dco_clk); #1;
        check("data_valid", 64'(deser.data_valid), 64'(exp_valid));
        check("locked",     64'(deser.locked),     64'(exp_locked));
        check("slip_count", 64'(deser.slip_count), 64'(exp_slip));
        check("align_err",  64'(deser.align_err),  64'(exp_err));
        check("data_out",   64'(deser.data_out),   64'(exp_data));
        obs_err   += int'(deser.align_err);
        obs_valid += int'(deser.data_valid);
        {lvds_frame, lvds_data} = r;
        @(posedge dco_clk);
        model_edge(r, f);
        #1;
        {lvds_frame, lvds_data} = f;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},   64'(deser.data_out),   64'd0);
        check({tag, "_valid"},  64'(deser.data_valid), 64'd0);
        check({tag, "_locked"}, 64'(deser.locked),     64'd0);
        check({tag, "_slip"},   64'(deser.slip_count), 64'd0);
        check({tag, "_err"},    64'(deser.align_err),  64'd0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is exercised off the edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (6) begin
            @(negedge dco_clk); #1;
            {lvds_frame, lvds_data} = 3'($urandom);
            align_en = 1'($urandom);
            check_zero("rst_hold");
        end
        {lvds_frame, lvds_data} = '0;
        @(posedge dco_clk); #1;
        rst_n = 1'b1;
        words.delete();
        corrupt.delete();
        model_reset();
    endtask

    int w0;

    initial begin
        model_reset();

        // Aligned at slip 0: enable once windows are full, lock after 4 strobes.
        do_reset();
        off = 4; fix_l0 = 1; l0_word = 16'h1234; frame_zero = 0;
        align_en = 0;
        run(24);
        align_en = 1;
        run(24);
        check("A_locked_early", 64'(deser.locked), 64'd0);
        run(8);
        check("A_locked",  64'(deser.locked),          64'd1);
        check("A_slip",    64'(deser.slip_count),      64'd0);
        check("A_lane0",   64'(deser.data_out[15:0]),  64'h1234);

        // Boundary 6 bit-times off: search must settle at slip 6.
        do_reset();
        off = 10; fix_l0 = 1; l0_word = 16'h5AC3; align_en = 1;
        run(200);
        check("B_locked", 64'(deser.locked),         64'd1);
        check("B_slip",   64'(deser.slip_count),     64'd6);
        check("B_lane0",  64'(deser.data_out[15:0]), 64'h5AC3);

        // One bad frame word is tolerated; two in a row drop and relock.
        obs_err = 0;
        w0 = (2 * m_k + off) / W;
        corrupt[w0 + 2] = 1;
        run(48);
        check("C1_locked", 64'(deser.locked), 64'd1);
        check("C1_err",    64'(obs_err),      64'd0);
        w0 = (2 * m_k + off) / W;
        corrupt[w0 + 2] = 1;
        corrupt[w0 + 3] = 1;
        run(80);
        check("C2_err",    64'(obs_err),          64'd1);
        check("C2_locked", 64'(deser.locked),     64'd1);
        check("C2_slip",   64'(deser.slip_count), 64'd6);

        // Disabling alignment drops lock, holds slip, keeps data flowing.
        align_en = 0;
        obs_valid = 0;
        run(32);
        check("D_valid_cnt", 64'(obs_valid),          64'd4);
        check("D_locked",    64'(deser.locked),       64'd0);
        check("D_slip",      64'(deser.slip_count),   64'd6);
        align_en = 1;
        run(48);
        check("D_relock", 64'(deser.locked), 64'd1);

        // Mid-stream reset restarts alignment from slip 0.
        run(3);
        do_reset();
        off = 10; fix_l0 = 0; align_en = 1;
        run(200);
        check("E_locked", 64'(deser.locked),     64'd1);
        check("E_slip",   64'(deser.slip_count), 64'd6);

        // Dead frame lane: a sweep error every 16 strobes, slip keeps cycling.
        do_reset();
        frame_zero = 1; align_en = 1; obs_err = 0;
        run(264);
        check("F_err_cnt", 64'(obs_err),          64'd2);
        check("F_slip",    64'(deser.slip_count), 64'd1);
        check("F_locked",  64'(deser.locked),     64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_deser_align.md
DDR_DESER_ALIGN -- requirements
Module: ddr_deser_align

Interface
REQ-001 SHALL have parameter LANES, default 8, number of ADC data lanes (1..16).
REQ-002 SHALL have parameter WORD_BITS, default 16, bits per sample word per lane; even, 4..32.
REQ-003 SHALL have parameter FRAME_PATTERN, default 16'hFF00 (WORD_BITS wide), the expected frame-lane word.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, consecutive frame matches required to lock (1..15).
REQ-005 SHALL have port dco_clk  in  1  DDR bit clock; all logic in this domain.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port lvds_data  in  LANES  serial DDR data lanes.
REQ-008 SHALL have port lvds_frame  in  1  serial DDR frame (FCO) lane.
REQ-009 SHALL have port align_en  in  1  enables alignment search/tracking.
REQ-010 SHALL have port data_out  out  LANES*WORD_BITS  aligned words; lane i occupies bits [i*WORD_BITS +: WORD_BITS].
REQ-011 SHALL have port data_valid  out  1  one-cycle strobe qualifying data_out.
REQ-012 SHALL have port locked  out  1  frame alignment achieved.
REQ-013 SHALL have port slip_count  out  $clog2(WORD_BITS)  current bit-slip offset.
REQ-014 SHALL have port align_err  out  1  one-cycle pulse on lock loss or failed full sweep.

Function
REQ-015 SHALL capture every lane (data and frame) on posedge into rise_q and on negedge into fall_q.
REQ-016 SHALL, on each posedge, shift the pair {rise_q, fall_q} into a per-lane 2*WORD_BITS shift register, rise_q as older bit; newest bit at LSB.
REQ-017 SHALL run a free word counter 0..WORD_BITS/2-1 on posedge; a strobe occurs when counter = WORD_BITS/2-1.
REQ-018 SHALL, on strobe, extract window sr[slip_count +: WORD_BITS] per lane and register into data_out with data_valid=1 one cycle later; data_valid is 0 otherwise.
REQ-019 SHALL emit data_valid every WORD_BITS/2 cycles regardless of lock state or align_en.
REQ-020 SHALL implement FSM states SEARCH, CHECK, LOCKED, evaluated only at strobes using the frame-lane window.
REQ-021 SEARCH: match -> CHECK, match_cnt=1 (LOCK_COUNT=1: -> LOCKED directly); mismatch -> slip_count+1 mod WORD_BITS.
REQ-022 CHECK: match -> match_cnt+1, at LOCK_COUNT -> LOCKED; mismatch -> SEARCH, slip_count+1, match_cnt=0.
REQ-023 LOCKED: single mismatch tolerated (miss flag set); second consecutive mismatch -> SEARCH, align_err pulse, locked=0, slip_count unchanged; match clears miss flag.
REQ-024 SHALL pulse align_err when WORD_BITS consecutive SEARCH mismatches occur (full sweep, slip wraps WORD_BITS-1 -> 0); sweep counter restarts.
REQ-025 locked SHALL equal (state==LOCKED), registered.
REQ-026 align_en=0 SHALL force SEARCH, hold slip_count, clear match/miss/sweep counters, suppress align_err; data path continues.
REQ-027 slip_count change SHALL take effect on the next strobe's extraction.

Reset
REQ-028 rst_n low SHALL asynchronously clear capture regs, shift regs, word counter, data_out, data_valid, locked, slip_count, align_err, all counters; FSM = SEARCH.
REQ-029 Reset deassertion mid-stream SHALL restart word counter at 0 and alignment from slip_count=0.

Structure
REQ-030 Shared package adc_fe_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-031 SHALL use one sub-module ddr_lane_shifter (DDR capture, shift register, window extraction), instantiated LANES+1 times.

Verification
REQ-032 Reset: rst_n low with toggling inputs -> all outputs 0, slip_count=0.
REQ-033 WORD_BITS=16, LANES=2, frame word aligned at slip 0, lane0=16'h1234 -> locked at strobe 4 (+1 cycle), data_out[15:0]=16'h1234.
REQ-034 Frame boundary 6 bit-times before strobe -> slip_count settles at 6, locked=1, data words correct.
REQ-035 Locked, one corrupted frame word -> locked stays 1; two consecutive -> align_err one pulse, locked=0, relock at same slip.
REQ-036 Frame lane constant 0 -> align_err pulse every 16 strobes, slip_count cycles 0..15.
REQ-037 align_en=0 while locked -> locked=0, slip_count held, data_valid continues every 8 cycles.
